// File: rtl/lcd_scan_ctrl.sv
// Monochrome STN panel scan controller: fetches framebuffer bytes one row at a time
// and shifts them out as BUS_W-wide beats with LP/FLM/M panel timing.
module lcd_scan_ctrl #(
  parameter int          RES_X    = 320,
  parameter int          RES_Y    = 240,
  parameter int          BUS_W    = 4,
  parameter int          LP_WIDTH = 1,
  parameter int          M_LINES  = 0,
  parameter logic [31:0] FB_BASE  = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             invert,
  input  logic             blank,
  output logic             fb_rd,
  output logic [31:0]      fb_addr,
  input  logic [7:0]       fb_data,
  output logic [BUS_W-1:0] data,
  output logic             dclk,
  output logic             lp,
  output logic             flm,
  output logic             m,
  output logic [15:0]      row,
  output logic             frame_start
);

  localparam int BEATS  = RES_X / BUS_W;
  localparam int BPR    = RES_X / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LPC_W  = (LP_WIDTH > 1) ? $clog2(LP_WIDTH) : 1;
  localparam int MLIM   = (M_LINES > 0) ? M_LINES - 1 : 0;
  localparam int MC_W   = (MLIM > 0) ? $clog2(MLIM + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_PREFETCH, S_SHIFT, S_TAIL} state_e;

  state_e            state_q;
  logic [LPC_W-1:0]  lpc_q;
  logic [BEAT_W-1:0] beat_q;
  logic              phase_q;
  logic [15:0]       row_q;
  logic              m_q;
  logic [MC_W-1:0]   mcnt_q;
  logic [31:0]       addr_q;
  logic [7:0]        byte_q;
  logic              fb_rd_q, lp_q, flm_q, dclk_q, fs_q;

  logic [15:0]      row_d, row_start;
  logic             start_row, m_tog, sub, last_sub, last_beat, lpc_done;
  logic             first_low, fetch_next;
  logic [31:0]      row_base;
  logic [7:0]       src;
  logic [BUS_W-1:0] pix;

  assign row_d      = (row_q == 16'(RES_Y - 1)) ? 16'd0 : row_q + 16'd1;
  assign row_start  = (state_q == S_TAIL) ? row_d : row_q;
  assign start_row  = en && ((state_q == S_IDLE) || (state_q == S_TAIL));
  assign m_tog      = (M_LINES == 0) ? (row_start == 16'd0) : (mcnt_q == MC_W'(MLIM));
  assign sub        = (BUS_W == 4) ? beat_q[0] : 1'b0;
  assign last_sub   = (BUS_W == 8) || beat_q[0];
  assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));
  assign lpc_done   = (lpc_q == LPC_W'(LP_WIDTH - 1));
  assign first_low  = (state_q == S_SHIFT) && !phase_q && !sub;
  assign fetch_next = (state_q == S_SHIFT) && !phase_q && last_sub && !last_beat;
  assign row_base   = FB_BASE + 32'(row_q) * 32'(BPR);

  // Read data arrives during the first low phase of a byte; later beats use the held copy.
  assign src = first_low ? fb_data : byte_q;

  generate
    if (BUS_W == 8) begin : g_bus8
      for (genvar i = 0; i < 8; i++) begin : g_bit
        assign pix[i] = src[7-i];
      end
    end else begin : g_bus4
      for (genvar i = 0; i < 4; i++) begin : g_bit
        assign pix[i] = sub ? src[3-i] : src[7-i];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lpc_q   <= '0;
      beat_q  <= '0;
      phase_q <= 1'b0;
      row_q   <= '0;
      m_q     <= 1'b0;
      mcnt_q  <= '0;
      fb_rd_q <= 1'b0;
      lp_q    <= 1'b0;
      flm_q   <= 1'b0;
      dclk_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      fb_rd_q <= 1'b0;
      fs_q    <= 1'b0;
      case (state_q)
        S_LATCH: begin
          if (lpc_done) begin
            state_q <= S_PREFETCH;
            lp_q    <= 1'b0;
            flm_q   <= 1'b0;
            fb_rd_q <= 1'b1;
          end else begin
            lpc_q <= lpc_q + LPC_W'(1);
          end
        end
        S_PREFETCH: begin
          state_q <= S_SHIFT;
          beat_q  <= '0;
          phase_q <= 1'b0;
        end
        S_SHIFT: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            dclk_q  <= 1'b1;
            fb_rd_q <= fetch_next;
          end else begin
            phase_q <= 1'b0;
            dclk_q  <= 1'b0;
            if (last_beat) state_q <= S_TAIL;
            else           beat_q  <= beat_q + BEAT_W'(1);
          end
        end
        S_TAIL: begin
          row_q   <= row_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // Row entry overrides the TAIL/IDLE exit; M bias flips in the first LATCH cycle.
      if (start_row) begin
        state_q <= S_LATCH;
        row_q   <= row_start;
        lpc_q   <= '0;
        lp_q    <= 1'b1;
        flm_q   <= (row_start == 16'd0);
        fs_q    <= (row_start == 16'd0);
        if (m_tog) m_q <= ~m_q;
        if (M_LINES > 0) mcnt_q <= m_tog ? '0 : mcnt_q + MC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LATCH && lpc_done) addr_q <= row_base;
    else if (fetch_next)                addr_q <= addr_q + 32'd1;
    if (first_low) byte_q <= fb_data;
  end

  assign data        = ((state_q == S_SHIFT) && !blank) ? (invert ? ~pix : pix) : '0;
  assign fb_rd       = fb_rd_q;
  assign fb_addr     = addr_q;
  assign dclk        = dclk_q;
  assign lp          = lp_q;
  assign flm         = flm_q;
  assign m           = m_q;
  assign row         = row_q;
  assign frame_start = fs_q;

endmodule
